// File: rtl/mips_pkg.sv
// Shared types for the MIPS instruction-fetch front end.
// With IF_ALIGN_CHECK_EN defined, the IF/ID payload carries a misalign flag.
package mips_pkg;

  localparam int IF_ADDR_W  = 32;
  localparam int IF_INSTR_W = 32;

  // sll $0,$0,0
  localparam logic [IF_INSTR_W-1:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    PEND,
    DROP
  } fetch_state_e;

  typedef struct packed {
    logic [IF_INSTR_W-1:0] instr;
    logic [IF_ADDR_W-1:0]  pc;
    logic [IF_ADDR_W-1:0]  pc_plus4;
`ifdef IF_ALIGN_CHECK_EN
    logic                  misalign;
`endif
  } ifid_t;

  // Turns a payload into a bubble: NOP instruction, no flags, addresses kept.
  function automatic ifid_t as_bubble(input ifid_t d, input logic [IF_INSTR_W-1:0] nop);
    ifid_t p;
    p       = d;
    p.instr = nop;
`ifdef IF_ALIGN_CHECK_EN
    p.misalign = 1'b0;
`endif
    return p;
  endfunction

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register with a one-entry pending buffer that absorbs
// a fetch completing while decode is stalled.
module ifid_reg
  import mips_pkg::*;
#(
  parameter logic [IF_INSTR_W-1:0] NOP_INSTR = NOP_WORD
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  wr_en,
  input  ifid_t wr_data,
  input  logic  flush,
  input  logic  id_stall,
  output logic  valid,
  output ifid_t data,
  output logic  consume,
  output logic  can_load
);

  logic  valid_reg;
  logic  pend_valid_reg;
  ifid_t data_reg;
  ifid_t pend_reg;

  assign consume  = valid_reg && !id_stall;
  assign can_load = !valid_reg || consume;
  assign valid    = valid_reg;
  assign data     = data_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_reg      <= 1'b0;
      pend_valid_reg <= 1'b0;
      data_reg       <= as_bubble('0, NOP_INSTR);
      pend_reg       <= as_bubble('0, NOP_INSTR);
    end else if (flush) begin
      valid_reg      <= 1'b0;
      pend_valid_reg <= 1'b0;
      data_reg       <= as_bubble(data_reg, NOP_INSTR);
    end else if (can_load) begin
      if (pend_valid_reg) begin
        data_reg       <= pend_reg;
        valid_reg      <= 1'b1;
        pend_valid_reg <= 1'b0;
      end else if (wr_en) begin
        data_reg  <= wr_data;
        valid_reg <= 1'b1;
      end else begin
        valid_reg <= 1'b0;
        data_reg  <= as_bubble(data_reg, NOP_INSTR);
      end
    end else if (wr_en) begin
      // IF/ID is held by a stall: park the new word until decode drains
      pend_reg       <= wr_data;
      pend_valid_reg <= 1'b1;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: req/ack fetch FSM feeding the IF/ID register.
// IF_ALIGN_CHECK_EN adds ifid_misalign and skips memory for misaligned PCs.
module if_stage
  import mips_pkg::*;
#(
  parameter int                 ADDR_W    = IF_ADDR_W,
  parameter int                 INSTR_W   = IF_INSTR_W,
  parameter logic [INSTR_W-1:0] NOP_INSTR = NOP_WORD
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_W-1:0]  pc,
  input  logic               flush,
  input  logic               id_stall,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_ack,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               pc_advance,
  output logic               ifid_valid,
`ifdef IF_ALIGN_CHECK_EN
  output logic               ifid_misalign,
`endif
  output logic [INSTR_W-1:0] ifid_instr,
  output logic [ADDR_W-1:0]  ifid_pc,
  output logic [ADDR_W-1:0]  ifid_pc_plus4
);

  fetch_state_e      state_reg;
  logic              req_reg;
  logic              adv_reg;
  logic [ADDR_W-1:0] addr_reg;

  logic  wr_en;
  ifid_t wr_data;
  ifid_t ifid_q;
  logic  consume;
  logic  can_load;

  always_comb begin
    wr_en            = 1'b0;
    wr_data          = as_bubble('0, NOP_INSTR);
    wr_data.instr    = imem_rdata;
    wr_data.pc       = addr_reg;
    wr_data.pc_plus4 = addr_reg + ADDR_W'(4);
    if (state_reg == WAIT && imem_ack && !flush) begin
      wr_en = 1'b1;
    end
`ifdef IF_ALIGN_CHECK_EN
    if (state_reg == IDLE && !flush && !adv_reg && pc[1:0] != 2'b00) begin
      wr_en            = 1'b1;
      wr_data.instr    = NOP_INSTR;
      wr_data.pc       = pc;
      wr_data.pc_plus4 = pc + ADDR_W'(4);
      wr_data.misalign = 1'b1;
    end
`endif
  end

  // IDLE waits out the pc_advance cycle so it never samples a stale PC.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= IDLE;
      req_reg   <= 1'b0;
      adv_reg   <= 1'b0;
      addr_reg  <= '0;
    end else begin
      adv_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (!flush && !adv_reg) begin
`ifdef IF_ALIGN_CHECK_EN
            if (pc[1:0] != 2'b00) begin
              adv_reg   <= 1'b1;
              state_reg <= can_load ? IDLE : PEND;
            end else
`endif
            begin
              state_reg <= WAIT;
              req_reg   <= 1'b1;
              addr_reg  <= pc;
            end
          end
        end
        WAIT: begin
          if (flush) begin
            if (imem_ack) begin
              req_reg   <= 1'b0;
              state_reg <= IDLE;
            end else begin
              state_reg <= DROP;
            end
          end else if (imem_ack) begin
            req_reg   <= 1'b0;
            adv_reg   <= 1'b1;
            state_reg <= can_load ? IDLE : PEND;
          end
        end
        PEND: begin
          if (flush || consume) begin
            state_reg <= IDLE;
          end
        end
        DROP: begin
          if (imem_ack) begin
            req_reg   <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  ifid_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_ifid_reg (
    .clk      (clk),
    .reset    (reset),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .flush    (flush),
    .id_stall (id_stall),
    .valid    (ifid_valid),
    .data     (ifid_q),
    .consume  (consume),
    .can_load (can_load)
  );

  assign imem_req      = req_reg;
  assign imem_addr     = addr_reg;
  assign pc_advance    = adv_reg;
  assign ifid_instr    = ifid_q.instr;
  assign ifid_pc       = ifid_q.pc;
  assign ifid_pc_plus4 = ifid_q.pc_plus4;
`ifdef IF_ALIGN_CHECK_EN
  assign ifid_misalign = ifid_q.misalign;
`endif

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: memory and PC models plus an IF/ID scoreboard.
module tb_if_stage;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic        flush;
  logic        id_stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        pc_advance;
  logic        ifid_valid;
`ifdef IF_ALIGN_CHECK_EN
  logic        ifid_misalign;
`endif
  logic [31:0] ifid_instr;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_pc_plus4;

  if_stage dut (
    .clk           (clk),
    .reset         (reset),
    .pc            (pc),
    .flush         (flush),
    .id_stall      (id_stall),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .pc_advance    (pc_advance),
    .ifid_valid    (ifid_valid),
`ifdef IF_ALIGN_CHECK_EN
    .ifid_misalign (ifid_misalign),
`endif
    .ifid_instr    (ifid_instr),
    .ifid_pc       (ifid_pc),
    .ifid_pc_plus4 (ifid_pc_plus4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pc4;
  } exp_t;

  exp_t        sb_q[$];
  int          rise_q[$];
  logic [31:0] rise_addr[$];
  int          tests = 0;
  int          fails = 0;
  int          cycle = 0;
  int          adv_cnt = 0;
  int          wcnt = 0;
  int          mem_lat = 1;
  int          n;
  int          snap;
  logic        req_prev = 1'b0;
  logic        dropping = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Close out the current cycle (scoreboard), advance one clock, then run
  // the memory and pc_control models against the new outputs.
  task automatic tick();
    exp_t e;
    if (!reset) begin
      sb_q.delete();
      dropping = 1'b0;
    end else begin
      if (ifid_valid && !id_stall && !flush) begin
        tests++;
        assert (sb_q.size() != 0) else begin
          fails++;
          $error("FAIL sb_unexpected: observed pc %h, expected no live instruction", ifid_pc);
        end
        if (sb_q.size() != 0) begin
          e = sb_q.pop_front();
          chk("sb_instr", ifid_instr, e.instr);
          chk("sb_pc", ifid_pc, e.pc);
          chk("sb_pc_plus4", ifid_pc_plus4, e.pc4);
        end
      end
      if (flush) begin
        sb_q.delete();
        dropping = imem_req && !imem_ack;
      end else if (imem_ack) begin
        if (dropping) dropping = 1'b0;
        else sb_q.push_back('{mem_word(pc), pc, pc + 32'd4});
      end
    end
    @(posedge clk);
    #1;
    cycle++;
    if (imem_ack) begin
      imem_ack = 1'b0;
    end else if (imem_req) begin
      wcnt++;
      if (wcnt >= mem_lat) begin
        imem_ack   = 1'b1;
        imem_rdata = mem_word(imem_addr);
        wcnt       = 0;
      end
    end else begin
      wcnt = 0;
    end
    if (pc_advance) begin
      pc = pc + 32'd4;
      adv_cnt++;
    end
    if (imem_req && !req_prev) begin
      rise_q.push_back(cycle);
      rise_addr.push_back(imem_addr);
    end
    req_prev = imem_req;
  endtask

  initial begin
    reset = 1'b1; pc = 32'd0; flush = 1'b0; id_stall = 1'b0;
    imem_ack = 1'b0; imem_rdata = 32'd0;
    #1 reset = 1'b0;
    #2;
    chk("rst_imem_req", {31'd0, imem_req}, 32'd0);
    chk("rst_imem_addr", imem_addr, 32'd0);
    chk("rst_pc_advance", {31'd0, pc_advance}, 32'd0);
    chk("rst_ifid_valid", {31'd0, ifid_valid}, 32'd0);
    chk("rst_ifid_instr", ifid_instr, 32'h0000_0000);
    chk("rst_ifid_pc", ifid_pc, 32'd0);
    chk("rst_ifid_pc_plus4", ifid_pc_plus4, 32'd0);
    tick(); tick();
    reset = 1'b1;

    // Back-to-back fetches from pc=0 with a 1-cycle memory
    n = 0;
    while (!(ifid_valid && ifid_pc == 32'd8) && n < 30) begin tick(); n++; end
    chk("reach_pc8_in_budget", {31'd0, n < 30}, 32'd1);
    id_stall = 1'b1;
    chk("first_three_reqs", rise_q.size(), 32'd3);
    chk("adv_after_three", adv_cnt, 32'd3);
    if (rise_q.size() >= 3) begin
      chk("first_req_addr", rise_addr[0], 32'd0);
      chk("issue_interval_a", rise_q[1] - rise_q[0], 32'd3);
      chk("issue_interval_b", rise_q[2] - rise_q[1], 32'd3);
    end

    // Decode stalled with pc=8 held; fetch of 12 parks in the pending buffer
    repeat (6) tick();
    chk("stall_hold_valid", {31'd0, ifid_valid}, 32'd1);
    chk("stall_hold_pc", ifid_pc, 32'd8);
    chk("stall_no_req", {31'd0, imem_req}, 32'd0);
    chk("stall_req_count", rise_q.size(), 32'd4);
    chk("stall_adv_count", adv_cnt, 32'd4);
    id_stall = 1'b0;
    tick();
    chk("pend_to_ifid_pc", ifid_pc, 32'd12);
    chk("pend_to_ifid_instr", ifid_instr, mem_word(32'd12));
    chk("pend_to_ifid_valid", {31'd0, ifid_valid}, 32'd1);
    mem_lat = 3;

    // Flush while waiting on fetch of 16 -> dropped, branch target 2000 next
    n = 0;
    while (!(imem_req && imem_addr == 32'd16) && n < 10) begin tick(); n++; end
    chk("req16_in_budget", {31'd0, n < 10}, 32'd1);
    snap = adv_cnt;
    flush = 1'b1; pc = 32'd2000;
    tick();
    flush = 1'b0;
    chk("drop_req_held", {31'd0, imem_req}, 32'd1);
    chk("drop_ifid_valid", {31'd0, ifid_valid}, 32'd0);
    n = 0;
    while (!(imem_req && imem_addr == 32'd2000) && n < 12) begin tick(); n++; end
    chk("target_req_in_budget", {31'd0, n < 12}, 32'd1);
    chk("drop_no_advance", adv_cnt, snap);
    chk("drop_nothing_loaded", {31'd0, ifid_valid}, 32'd0);

    // Flush in the same cycle as the ack
    n = 0;
    while (!imem_ack && n < 8) begin tick(); n++; end
    chk("ack2000_in_budget", {31'd0, n < 8}, 32'd1);
    flush = 1'b1; pc = 32'd3000; mem_lat = 1;
    tick();
    flush = 1'b0;
    chk("coinc_ifid_valid", {31'd0, ifid_valid}, 32'd0);
    chk("coinc_ifid_instr", ifid_instr, 32'h0000_0000);
    chk("coinc_no_advance", {31'd0, pc_advance}, 32'd0);
    chk("coinc_req_dropped", {31'd0, imem_req}, 32'd0);
    tick();
    chk("coinc_next_req", {31'd0, imem_req}, 32'd1);
    chk("coinc_next_addr", imem_addr, 32'd3000);

    // Flush clears a full IF/ID even while decode is stalled
    n = 0;
    while (!ifid_valid && n < 8) begin tick(); n++; end
    chk("load3000_pc", ifid_pc, 32'd3000);
    id_stall = 1'b1; flush = 1'b1; pc = 32'd5000;
    tick();
    flush = 1'b0;
    chk("stall_flush_valid", {31'd0, ifid_valid}, 32'd0);
    chk("stall_flush_instr", ifid_instr, 32'h0000_0000);

`ifdef IF_ALIGN_CHECK_EN
    // Misaligned PC loads a NOP bubble without touching memory
    flush = 1'b1; pc = 32'd6;
    tick();
    flush = 1'b0;
    snap = rise_q.size();
    tick();
    chk("mis_valid", {31'd0, ifid_valid}, 32'd1);
    chk("mis_flag", {31'd0, ifid_misalign}, 32'd1);
    chk("mis_instr", ifid_instr, 32'h0000_0000);
    chk("mis_pc", ifid_pc, 32'd6);
    repeat (3) tick();
    chk("mis_no_req", rise_q.size(), snap);
`endif

    // PC wrap: pc+4 of the last word is 0
    id_stall = 1'b0; flush = 1'b1; pc = 32'hFFFF_FFFC;
    tick();
    flush = 1'b0;
    n = 0;
    while (!(ifid_valid && ifid_pc == 32'hFFFF_FFFC) && n < 10) begin tick(); n++; end
    chk("wrap_in_budget", {31'd0, n < 10}, 32'd1);
    chk("wrap_pc_plus4", ifid_pc_plus4, 32'd0);
    chk("wrap_instr", ifid_instr, mem_word(32'hFFFF_FFFC));

    // Asynchronous reset in the middle of a request
    mem_lat = 3;
    n = 0;
    while (!imem_req && n < 10) begin tick(); n++; end
    chk("req_before_reset", {31'd0, imem_req}, 32'd1);
    #3 reset = 1'b0;
    #1;
    chk("async_rst_req", {31'd0, imem_req}, 32'd0);
    chk("async_rst_addr", imem_addr, 32'd0);
    chk("async_rst_adv", {31'd0, pc_advance}, 32'd0);
    chk("async_rst_valid", {31'd0, ifid_valid}, 32'd0);
    chk("async_rst_instr", ifid_instr, 32'h0000_0000);
    chk("async_rst_pc", ifid_pc, 32'd0);
    chk("async_rst_pc_plus4", ifid_pc_plus4, 32'd0);
    tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
